// File: rtl/solve_sequencer_if.sv
// solve_sequencer_if: parser/solver/assembler handshakes and shared FIFO port of the board-flow controller.
interface solve_sequencer_if #(
    parameter int MAX_ROWS = 11,
    parameter int MAX_COLS = 11,
    parameter int LINE_W   = 16
);
    localparam int RW = $clog2(MAX_ROWS + 1);
    localparam int CW = $clog2(MAX_COLS + 1);
    localparam int SW = MAX_ROWS * MAX_COLS;

    logic              clear_i;
    logic              parsed_i;
    logic [RW-1:0]     m_i;
    logic [CW-1:0]     n_i;
    logic              parse_wr_i;
    logic [LINE_W-1:0] parse_line_i;
    logic              solve_wr_i;
    logic [LINE_W-1:0] solve_line_i;
    logic              solved_i;
    logic [SW-1:0]     solution_i;
    logic              assembled_i;
    logic              fifo_full_i;
    logic              fifo_wr_o;
    logic [LINE_W-1:0] fifo_din_o;
    logic              fifo_srst_o;
    logic              solve_start_o;
    logic              send_start_o;
    logic [RW-1:0]     m_o;
    logic [CW-1:0]     n_o;
    logic [SW-1:0]     solution_o;
    logic [2:0]        state_o;
    logic [1:0]        err_code_o;
    logic [7:0]        boards_done_o;

    modport slave (
        input  clear_i, parsed_i, m_i, n_i, parse_wr_i, parse_line_i, solve_wr_i, solve_line_i,
               solved_i, solution_i, assembled_i, fifo_full_i,
        output fifo_wr_o, fifo_din_o, fifo_srst_o, solve_start_o, send_start_o, m_o, n_o,
               solution_o, state_o, err_code_o, boards_done_o
    );

    modport master (
        output clear_i, parsed_i, m_i, n_i, parse_wr_i, parse_line_i, solve_wr_i, solve_line_i,
               solved_i, solution_i, assembled_i, fifo_full_i,
        input  fifo_wr_o, fifo_din_o, fifo_srst_o, solve_start_o, send_start_o, m_o, n_o,
               solution_o, state_o, err_code_o, boards_done_o
    );
endinterface

// File: rtl/solve_sequencer.sv
// solve_sequencer: RECEIVE/SOLVE/FLUSH/TRANSMIT/ERROR board-flow FSM with shared line FIFO arbitration.
// Optional solve watchdog enabled by defining SOLVE_TIMEOUT_EN.
module solve_sequencer #(
    parameter int MAX_ROWS       = 11,
    parameter int MAX_COLS       = 11,
    parameter int LINE_W         = 16,
    parameter int FLUSH_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input logic               clk,
    input logic               rst_n,
    solve_sequencer_if.slave  bus
);
    localparam int RW = $clog2(MAX_ROWS + 1);
    localparam int CW = $clog2(MAX_COLS + 1);
    localparam int SW = MAX_ROWS * MAX_COLS;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        RECEIVE  = 3'd0,
        SOLVE    = 3'd1,
        FLUSH    = 3'd2,
        TRANSMIT = 3'd3,
        ERROR    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    boards_q, boards_d;
    logic [RW-1:0] m_q, m_d;
    logic [CW-1:0] n_q, n_d;
    logic [SW-1:0] sol_q, sol_d;
    logic          solve_start_q, solve_start_d;
    logic          send_start_q, send_start_d;
    logic          src_wr, overflow, dims_ok, timeout;

    // A solver write-back coinciding with solved_i belongs to a finished board, so it is dropped.
    always_comb begin
        src_wr   = (state_q == RECEIVE) ? bus.parse_wr_i :
                   (state_q == SOLVE)   ? (bus.solve_wr_i & ~bus.solved_i) : 1'b0;
        overflow = src_wr & bus.fifo_full_i;
        dims_ok  = (bus.m_i != '0) && (bus.m_i <= RW'(MAX_ROWS)) &&
                   (bus.n_i != '0) && (bus.n_i <= CW'(MAX_COLS));
    end

`ifdef SOLVE_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = (state_q == SOLVE) ? tmo_cnt_q + 32'd1 : 32'd0;
        timeout   = (state_q == SOLVE) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt_q <= 32'd0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYCLES);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RECEIVE;
        else        state_q <= state_d;
    end

    // Overflow outranks every phase event; solved_i outranks the watchdog.
    always_comb begin
        state_d = state_q;
        if (overflow) state_d = ERROR;
        else begin
            case (state_q)
                RECEIVE:  if (bus.parsed_i) state_d = dims_ok ? SOLVE : ERROR;
                SOLVE:    if (bus.solved_i) state_d = FLUSH;
                          else if (timeout) state_d = ERROR;
                FLUSH:    if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) state_d = TRANSMIT;
                TRANSMIT: if (bus.assembled_i) state_d = RECEIVE;
                ERROR:    if (bus.clear_i) state_d = RECEIVE;
                default:  state_d = RECEIVE;
            endcase
        end
    end

    always_comb begin
        m_d           = (state_q == RECEIVE && bus.parsed_i && !overflow) ? bus.m_i : m_q;
        n_d           = (state_q == RECEIVE && bus.parsed_i && !overflow) ? bus.n_i : n_q;
        sol_d         = (state_q == SOLVE && bus.solved_i) ? bus.solution_i : sol_q;
        flush_cnt_d   = (state_q == FLUSH) ? flush_cnt_q + FW'(1) : '0;
        boards_d      = (state_q == TRANSMIT && bus.assembled_i && boards_q != 8'hFF) ? boards_q + 8'd1 : boards_q;
        solve_start_d = (state_q == RECEIVE) && (state_d == SOLVE);
        send_start_d  = (state_q == FLUSH) && (state_d == TRANSMIT);
        err_code_d    = (state_q == ERROR)   ? (bus.clear_i ? 2'd0 : err_code_q) :
                        overflow             ? 2'd1 :
                        (state_d != ERROR)   ? 2'd0 :
                        (state_q == RECEIVE) ? 2'd2 : 2'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q   <= '0;
            err_code_q    <= 2'd0;
            boards_q      <= 8'd0;
            m_q           <= '0;
            n_q           <= '0;
            sol_q         <= '0;
            solve_start_q <= 1'b0;
            send_start_q  <= 1'b0;
        end else begin
            flush_cnt_q   <= flush_cnt_d;
            err_code_q    <= err_code_d;
            boards_q      <= boards_d;
            m_q           <= m_d;
            n_q           <= n_d;
            sol_q         <= sol_d;
            solve_start_q <= solve_start_d;
            send_start_q  <= send_start_d;
        end
    end

    always_comb begin
        bus.fifo_wr_o     = src_wr & ~bus.fifo_full_i;
        bus.fifo_din_o    = (state_q == RECEIVE) ? bus.parse_line_i :
                            (state_q == SOLVE)   ? bus.solve_line_i : '0;
        bus.fifo_srst_o   = ~rst_n | (state_q == FLUSH) | (state_q == ERROR);
        bus.solve_start_o = solve_start_q;
        bus.send_start_o  = send_start_q;
        bus.m_o           = m_q;
        bus.n_o           = n_q;
        bus.solution_o    = sol_q;
        bus.state_o       = state_q;
        bus.err_code_o    = err_code_q;
        bus.boards_done_o = boards_q;
    end
endmodule

// File: tb/tb_solve_sequencer.sv
// tb_solve_sequencer: table-driven per-cycle vectors plus hand sequences for timeout, saturation and async reset.
module tb_solve_sequencer;
    localparam logic [120:0] SOL = {11{11'h5A3}};

    typedef struct {
        logic [6:0] in;
        logic [3:0] m, n;
        logic [2:0] st;
        logic       wr;
        logic [1:0] src;
        logic       srst, ss, sd;
        logic [1:0] err;
        logic [7:0] bd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];

    solve_sequencer_if #(.MAX_ROWS(11), .MAX_COLS(11), .LINE_W(16)) bus ();

    solve_sequencer #(
        .MAX_ROWS(11), .MAX_COLS(11), .LINE_W(16), .FLUSH_CYCLES(2), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t V(input logic [6:0] in, input logic [3:0] m, input logic [3:0] n,
                               input logic [2:0] st, input logic wr, input logic [1:0] src,
                               input logic srst, input logic ss, input logic sd,
                               input logic [1:0] err, input logic [7:0] bd);
        vec_t v;
        v.in = in; v.m = m; v.n = n; v.st = st; v.wr = wr; v.src = src;
        v.srst = srst; v.ss = ss; v.sd = sd; v.err = err; v.bd = bd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.parse_wr_i = 0; bus.solve_wr_i = 0; bus.fifo_full_i = 0; bus.parsed_i = 0;
        bus.solved_i = 0; bus.assembled_i = 0; bus.clear_i = 0;
        bus.m_i = 0; bus.n_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Input bits in each row: {parse_wr, solve_wr, fifo_full, parsed, solved, assembled, clear}.
    task automatic apply(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            vec_t v;
            logic [15:0] pl, sl;
            v  = tbl[i];
            pl = 16'hA000 | 16'(i);
            sl = 16'h5000 | 16'(i);
            {bus.parse_wr_i, bus.solve_wr_i, bus.fifo_full_i, bus.parsed_i,
             bus.solved_i, bus.assembled_i, bus.clear_i} = v.in;
            bus.m_i = v.m;
            bus.n_i = v.n;
            bus.parse_line_i = pl;
            bus.solve_line_i = sl;
            #1;
            chk($sformatf("row%0d state", i), 128'(bus.state_o), 128'(v.st));
            chk($sformatf("row%0d fifo_wr", i), 128'(bus.fifo_wr_o), 128'(v.wr));
            chk($sformatf("row%0d fifo_din", i), 128'(bus.fifo_din_o),
                128'(v.src == 2'd1 ? pl : v.src == 2'd2 ? sl : 16'h0));
            chk($sformatf("row%0d fifo_srst", i), 128'(bus.fifo_srst_o), 128'(v.srst));
            chk($sformatf("row%0d solve_start", i), 128'(bus.solve_start_o), 128'(v.ss));
            chk($sformatf("row%0d send_start", i), 128'(bus.send_start_o), 128'(v.sd));
            chk($sformatf("row%0d err_code", i), 128'(bus.err_code_o), 128'(v.err));
            chk($sformatf("row%0d boards", i), 128'(bus.boards_done_o), 128'(v.bd));
            step();
        end
        idle();
    endtask

    task automatic run_board();
        bus.parsed_i = 1; bus.m_i = 2; bus.n_i = 2;
        step();
        idle(); bus.solved_i = 1;
        step();
        idle();
        step();
        step();
        bus.assembled_i = 1;
        step();
        idle();
    endtask

    initial begin
        idle();
        bus.parse_line_i = 0; bus.solve_line_i = 0; bus.solution_i = SOL;
        // T1 happy path
        tbl.push_back(V(7'b1000000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(7'b1000000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(7'b1000000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(7'b1000000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(7'b1000000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(7'b0001000, 11, 11, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(7'b0100000, 0, 0, 1, 1, 2, 0, 1, 0, 0, 0));
        tbl.push_back(V(7'b0100000, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(V(7'b0100000, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(V(7'b0100100, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(V(7'b0000000, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(V(7'b0000000, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(V(7'b0000000, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V(7'b0000010, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(7'b0000000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        // T4 cross-source writes and ignored off-phase events
        tbl.push_back(V(7'b0100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(V(7'b0001000, 3, 4, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(V(7'b1000000, 0, 0, 1, 0, 2, 0, 1, 0, 0, 1));
        tbl.push_back(V(7'b0001011, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1));
        tbl.push_back(V(7'b0000100, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1));
        tbl.push_back(V(7'b0000000, 0, 0, 2, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(V(7'b0000000, 0, 0, 2, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(V(7'b0000000, 0, 0, 3, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(V(7'b0000010, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(7'b0000000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        // T2 bad dims m=0, then clear
        tbl.push_back(V(7'b0001000, 0, 5, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(V(7'b0000000, 0, 0, 4, 0, 0, 1, 0, 0, 2, 2));
        tbl.push_back(V(7'b0000001, 0, 0, 4, 0, 0, 1, 0, 0, 2, 2));
        tbl.push_back(V(7'b0000000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        // T3 overflow
        tbl.push_back(V(7'b1010000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(V(7'b0000000, 0, 0, 4, 0, 0, 1, 0, 0, 1, 2));
        tbl.push_back(V(7'b0000001, 0, 0, 4, 0, 0, 1, 0, 0, 1, 2));
        tbl.push_back(V(7'b0000000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        // Dimension boundaries m=12, n=12; full flag alone is harmless
        tbl.push_back(V(7'b0001000, 12, 11, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(V(7'b0000000, 0, 0, 4, 0, 0, 1, 0, 0, 2, 2));
        tbl.push_back(V(7'b0000001, 0, 0, 4, 0, 0, 1, 0, 0, 2, 2));
        tbl.push_back(V(7'b0010000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(V(7'b0000000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(V(7'b0001000, 11, 12, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(V(7'b0000000, 0, 0, 4, 0, 0, 1, 0, 0, 2, 2));
        tbl.push_back(V(7'b0000001, 0, 0, 4, 0, 0, 1, 0, 0, 2, 2));
        tbl.push_back(V(7'b0000000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));

        #3;
        chk("reset state", 128'(bus.state_o), 128'(0));
        chk("reset srst", 128'(bus.fifo_srst_o), 128'(1));
        chk("reset boards", 128'(bus.boards_done_o), 128'(0));
        chk("reset err", 128'(bus.err_code_o), 128'(0));
        chk("reset fifo_wr", 128'(bus.fifo_wr_o), 128'(0));
        #9 rst_n = 1'b1;
        step();

        apply(0, 15);
        chk("T1 m_o", 128'(bus.m_o), 128'(11));
        chk("T1 n_o", 128'(bus.n_o), 128'(11));
        chk("T1 solution_o", 128'(bus.solution_o), 128'(SOL));
        apply(15, tbl.size());
        chk("dims kept m_o", 128'(bus.m_o), 128'(11));
        chk("dims kept n_o", 128'(bus.n_o), 128'(12));

`ifdef SOLVE_TIMEOUT_EN
        bus.parsed_i = 1; bus.m_i = 2; bus.n_i = 2;
        step();
        idle();
        repeat (99) step();
        chk("T5 still solving at 99", 128'(bus.state_o), 128'(1));
        step();
        chk("T5 timeout state", 128'(bus.state_o), 128'(4));
        chk("T5 timeout err", 128'(bus.err_code_o), 128'(3));
        bus.clear_i = 1;
        step();
        idle();
        bus.parsed_i = 1; bus.m_i = 2; bus.n_i = 2;
        step();
        idle();
        repeat (99) step();
        bus.solved_i = 1;
        step();
        idle();
        chk("T5 solved at 99 wins", 128'(bus.state_o), 128'(2));
`else
        bus.parsed_i = 1; bus.m_i = 2; bus.n_i = 2;
        step();
        idle();
        repeat (150) step();
        chk("no timeout state", 128'(bus.state_o), 128'(1));
        chk("no timeout err", 128'(bus.err_code_o), 128'(0));
        bus.solved_i = 1;
        step();
        idle();
`endif
        step();
        step();
        bus.assembled_i = 1;
        step();
        idle();
        chk("board 3 done", 128'(bus.boards_done_o), 128'(3));

        repeat (252) run_board();
        chk("boards at 255", 128'(bus.boards_done_o), 128'(255));
        run_board();
        chk("boards saturate", 128'(bus.boards_done_o), 128'(255));
        chk("state after saturate", 128'(bus.state_o), 128'(0));

        // T6 async reset mid-SOLVE
        bus.parsed_i = 1; bus.m_i = 5; bus.n_i = 6;
        step();
        idle();
        chk("T6 in solve", 128'(bus.state_o), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("T6 reset state", 128'(bus.state_o), 128'(0));
        chk("T6 reset srst", 128'(bus.fifo_srst_o), 128'(1));
        chk("T6 reset boards", 128'(bus.boards_done_o), 128'(0));
        chk("T6 reset m_o", 128'(bus.m_o), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("T6 srst released", 128'(bus.fifo_srst_o), 128'(0));
        run_board();
        chk("T6 board after reset", 128'(bus.boards_done_o), 128'(1));
        chk("T6 m_o after reset", 128'(bus.m_o), 128'(2));
        chk("T6 state after reset", 128'(bus.state_o), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
